// File: rtl/inst_li_encode_if.sv
// Handshake bundle between a load-immediate requester and the encoder.
// The master drives requests and consumes instruction words; the slave is the encoder.
interface inst_li_encode_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rd;
    logic [31:0] req_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_last;
    logic        busy;

    modport master (
        output req_valid, req_rd, req_value, out_ready,
        input  req_ready, out_valid, out_inst, out_last, busy
    );

    modport slave (
        input  req_valid, req_rd, req_value, out_ready,
        output req_ready, out_valid, out_inst, out_last, busy
    );
endinterface

// File: rtl/inst_li_encode.sv
// Expands a 32-bit load-immediate into the shortest RV32I LUI/ADDI sequence,
// streamed one instruction word per handshake.
module inst_li_encode (
    input  logic             clk,
    input  logic             reset,
    inst_li_encode_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        EMIT_LUI,
        EMIT_ADDI
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state;
    state_t      state_next;
    logic [4:0]  rd_q;
    logic [19:0] upper_q;
    logic [11:0] lower_q;
    logic        need_addi;
    logic        follows_lui;

    logic        accept;
    logic        fire;
    logic [19:0] upper_in;
    logic [11:0] lower_in;
    logic [4:0]  rs1;

    // ADDI sign-extends its immediate, so a set bit 11 borrows one from the upper part.
    assign upper_in = bus.req_value[31:12] + {19'd0, bus.req_value[11]};
    assign lower_in = bus.req_value[11:0];
    assign accept   = bus.req_valid && (state == IDLE);
    assign fire     = (state != IDLE) && bus.out_ready;
    assign rs1      = follows_lui ? rd_q : 5'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // rd==0 collapses to a plain NOP by forcing a zero immediate into the ADDI path.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q        <= 5'd0;
            upper_q     <= 20'd0;
            lower_q     <= 12'd0;
            need_addi   <= 1'b0;
            follows_lui <= 1'b0;
        end else if (accept) begin
            rd_q        <= bus.req_rd;
            upper_q     <= upper_in;
            lower_q     <= (bus.req_rd == 5'd0) ? 12'd0 : lower_in;
            need_addi   <= (upper_in != 20'd0) && (lower_in != 12'd0);
            follows_lui <= 1'b0;
        end else if ((state == EMIT_LUI) && fire) begin
            follows_lui <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_inst  = NOP_INST;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (accept) begin
                    if ((bus.req_rd == 5'd0) || (upper_in == 20'd0)) begin
                        state_next = EMIT_ADDI;
                    end else begin
                        state_next = EMIT_LUI;
                    end
                end
            end
            EMIT_LUI: begin
                bus.out_valid = 1'b1;
                bus.out_last  = !need_addi;
                bus.out_inst  = {upper_q, rd_q, 7'b0110111};
                if (fire) begin
                    state_next = need_addi ? EMIT_ADDI : IDLE;
                end
            end
            EMIT_ADDI: begin
                bus.out_valid = 1'b1;
                bus.out_last  = 1'b1;
                bus.out_inst  = {lower_q, rs1, 3'b000, rd_q, 7'b0010011};
                if (fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_inst_li_encode.sv
// Self-checking bench for inst_li_encode: directed vector table, backpressure and
// reset corner cases, then random requests against an arithmetic reference model.
module tb_inst_li_encode;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    inst_li_encode_if bus ();

    inst_li_encode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, " out_last"},  32'(bus.out_last),  32'd0);
        checkOutput({tag, " out_inst"},  bus.out_inst,       32'h0000_0013);
        checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, " busy"},      32'(bus.busy),      32'd0);
    endtask

    task automatic checkWord(input logic [31:0] expected, input logic last);
        checkOutput("word out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("word out_inst",  bus.out_inst,       expected);
        checkOutput("word out_last",  32'(bus.out_last),  32'(last));
        checkOutput("word busy",      32'(bus.busy),      32'd1);
        checkOutput("word req_ready", 32'(bus.req_ready), 32'd0);
    endtask

    // Starts and ends on a falling edge with the encoder idle; stray req_valid
    // pulses while words are pending must not start another sequence.
    task automatic applyStimulus(input logic [4:0] rd, input logic [31:0] value,
                                 input int n, input logic [31:0] w0, input logic [31:0] w1,
                                 input int stall0, input int stall1);
        logic [31:0] expected;
        int          stall;
        checkOutput("req_ready before request", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_rd    = rd;
        bus.req_value = value;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_rd    = 5'($urandom);
        bus.req_value = $urandom;
        for (int i = 0; i < n; i++) begin
            expected = (i == 0) ? w0 : w1;
            stall    = (i == 0) ? stall0 : stall1;
            for (int s = 0; s <= stall; s++) begin
                bus.out_ready = (s == stall);
                bus.req_valid = (s != stall) && (s % 2 == 0);
                checkWord(expected, i == n - 1);
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'($urandom);
        checkIdle("bubble");
    endtask

    // Reference: the upper part is the value rounded to the nearest 4 KiB, which
    // absorbs the sign extension of the 12-bit ADDI immediate.
    function automatic void model(input logic [4:0] rd, input logic [31:0] v,
                                  output int n, output logic [31:0] w0,
                                  output logic [31:0] w1);
        logic [31:0] up;
        logic [31:0] lo;
        logic [31:0] r;
        up = (v + 32'h800) >> 12;
        lo = v & 32'hFFF;
        r  = 32'(rd);
        n  = 1;
        w1 = 32'h0000_0013;
        if (rd == 5'd0) begin
            w0 = 32'h0000_0013;
        end else if (up == 32'd0) begin
            w0 = (lo << 20) | (r << 7) | 32'h13;
        end else if (lo == 32'd0) begin
            w0 = (up << 12) | (r << 7) | 32'h37;
        end else begin
            n  = 2;
            w0 = (up << 12) | (r << 7) | 32'h37;
            w1 = (lo << 20) | (r << 15) | (r << 7) | 32'h13;
        end
    endfunction

    initial begin
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] value;
        logic [4:0]  rd;

        vecs[0] = '{5'd5,  32'h0000_0123, 1, 32'h1230_0293, 32'h0000_0013};
        vecs[1] = '{5'd10, 32'h1234_5000, 1, 32'h1234_5537, 32'h0000_0013};
        vecs[2] = '{5'd1,  32'h1234_5678, 2, 32'h1234_50B7, 32'h6780_8093};
        vecs[3] = '{5'd2,  32'h7FFF_F800, 2, 32'h8000_0137, 32'h8001_0113};
        vecs[4] = '{5'd3,  32'hFFFF_F800, 1, 32'h8000_0193, 32'h0000_0013};
        vecs[5] = '{5'd3,  32'h0000_0000, 1, 32'h0000_0193, 32'h0000_0013};
        vecs[6] = '{5'd0,  32'hDEAD_BEEF, 1, 32'h0000_0013, 32'h0000_0013};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_rd    = 5'd0;
        bus.req_value = 32'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].rd, vecs[i].value, vecs[i].n, vecs[i].w0, vecs[i].w1, 0, 0);
        end

        $display("[TB] backpressure on the first word");
        applyStimulus(5'd1, 32'h1234_5678, 2, 32'h1234_50B7, 32'h6780_8093, 3, 0);

        $display("[TB] reset while the ADDI word is pending");
        bus.req_valid = 1'b1;
        bus.req_rd    = 5'd1;
        bus.req_value = 32'h1234_5678;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkWord(32'h1234_50B7, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkWord(32'h6780_8093, 1'b1);
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        checkIdle("after mid-sequence reset");
        applyStimulus(5'd2, 32'h7FFF_F800, 2, 32'h8000_0137, 32'h8001_0113, 1, 2);

        $display("[TB] random requests against the reference model");
        for (int t = 0; t < 60; t++) begin
            rd    = 5'($urandom_range(0, 31));
            value = $urandom;
            case ($urandom_range(0, 4))
                0: value = value & 32'h0000_0FFF;
                1: value = value & 32'hFFFF_F000;
                2: value = {20'hFFFFF, 1'b1, value[10:0]};
                3: value = {value[31:12], 12'h800};
                default: ;
            endcase
            model(rd, value, n, w0, w1);
            applyStimulus(rd, value, n, w0, w1, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
